// File: rtl/rdata_lane_reducer.sv
// Purpose: sums all unsigned lanes of a programmed number of R-channel beats into one result.
// Latency: m_valid rises the cycle after the last beat; one beat per cycle while s_rvalid holds.
// Backpressure: s_rready only in ACCUM; result held until m_ready (RDATA_REDUCER_SATURATE_EN clamps).
module rdata_lane_reducer #(
    parameter int DATA_BITS  = 64,
    parameter int LANE_BITS  = 16,
    parameter int COUNT_BITS = 17,
    parameter int SUM_BITS   = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cfg_start,
    input  logic [COUNT_BITS-1:0] cfg_count,
    output logic                  busy,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_BITS-1:0]  s_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SUM_BITS-1:0]   m_sum,
    output logic [COUNT_BITS-1:0] m_beats
);

    localparam int LANES  = DATA_BITS / LANE_BITS;
    localparam int LSUM_W = LANE_BITS + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [COUNT_BITS-1:0] remaining;
    logic [LSUM_W-1:0]     lane_sum;
    logic [SUM_BITS-1:0]   acc_next;
    logic                  beat;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LSUM_W'(s_rdata[i*LANE_BITS +: LANE_BITS]);
        end
    end

`ifdef RDATA_REDUCER_SATURATE_EN
    // One extra bit above the wider operand catches the carry out for the clamp.
    localparam int ADD_W = ((SUM_BITS > LSUM_W) ? SUM_BITS : LSUM_W) + 1;
    logic [ADD_W-1:0] add_full;

    assign add_full = ADD_W'(m_sum) + ADD_W'(lane_sum);

    always_comb begin
        acc_next = add_full[SUM_BITS-1:0];
        if (add_full > ADD_W'({SUM_BITS{1'b1}})) begin
            acc_next = '1;
        end
    end
`else
    assign acc_next = m_sum + SUM_BITS'(lane_sum);
`endif

    assign beat = s_rvalid && s_rready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            s_rready  <= 1'b0;
            m_valid   <= 1'b0;
            m_sum     <= '0;
            m_beats   <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        m_sum     <= '0;
                        m_beats   <= '0;
                        remaining <= cfg_count;
                        busy      <= 1'b1;
                        if (cfg_count == '0) begin
                            state   <= DONE;
                            m_valid <= 1'b1;
                        end else begin
                            state    <= ACCUM;
                            s_rready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        m_sum     <= acc_next;
                        m_beats   <= m_beats + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == COUNT_BITS'(1)) begin
                            state    <= DONE;
                            s_rready <= 1'b0;
                            m_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    s_rready <= 1'b0;
                    m_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rdata_lane_reducer.md
# rdata_lane_reducer

Downstream consumer of the sequential-read generator's AXI read-data (R) channel. It accepts a programmed number of `DATA_BITS`-wide read beats and splits each beat into unsigned lanes. All lanes of all beats are summed into one accumulator, and the total is presented on a valid/ready result port. It gives the read stream a checkable end product: a known memory image yields a known sum.

## Interface
Parameters:
- `DATA_BITS`, 64, width of `s_rdata`; must be a multiple of `LANE_BITS`
- `LANE_BITS`, 16, width of each unsigned lane; `LANES = DATA_BITS / LANE_BITS`
- `COUNT_BITS`, 17, width of the beat count
- `SUM_BITS`, 32, accumulator and result width; must be ≥ `LANE_BITS`

Ports:
- `clock`  in  1  sole clock, rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- `cfg_start`  in  1  start pulse; sampled only in IDLE
- `cfg_count`  in  COUNT_BITS  number of beats to consume; sampled with `cfg_start`
- `busy`  out  1  high whenever state is not IDLE
- `s_rvalid`  in  1  read-data beat valid
- `s_rready`  out  1  read-data ready
- `s_rdata`  in  DATA_BITS  read-data beat
- `m_valid`  out  1  result valid
- `m_ready`  in  1  result accepted
- `m_sum`  out  SUM_BITS  accumulated sum
- `m_beats`  out  COUNT_BITS  beats actually consumed; equals `cfg_count`

## Operation
- Reset values:
  - state is IDLE.
  - `s_rready`, `m_valid` and `busy` are 0.
  - `m_sum`, `m_beats` and the remaining-beat counter are 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On `cfg_start=1`, clear the accumulator and beat counter, and latch `cfg_count` into `remaining`.
  - If `cfg_count==0`, go to DONE with sum 0. Otherwise go to ACCUM.
- ACCUM:
  - `s_rready=1`.
  - A beat is accepted on a cycle with `s_rvalid && s_rready`.
  - On each accepted beat: `lane_sum` is the sum of all `LANES` lanes, zero-extended to `SUM_BITS`. Then `acc <= acc + lane_sum`, `remaining` decrements and `m_beats` increments.
  - When the beat accepted has `remaining==1`, go to DONE.
- DONE:
  - `m_valid=1`, with `m_sum` and `m_beats` held stable.
  - On `m_valid && m_ready`, go to IDLE and drop `m_valid`.
- `cfg_start` outside IDLE is ignored and has no side effect.
- `s_rready` is 0 in IDLE and DONE, so beats presented there stay pending upstream.
- Arithmetic:
  - All values are unsigned.
  - `lane_sum` is computed at full width `LANE_BITS + clog2(LANES)`, then zero-extended.
  - Accumulator overflow behaviour is set by Configuration.
- Reset mid-operation: the block returns immediately to reset values and discards any partial sum. No result is emitted.

## Timing
- `s_rready`, `m_valid` and `busy` are decoded from registered state only. There is no combinational path from any input to any output.
- `cfg_start` sampled at edge T:
  - `busy=1` and `s_rready=1` from cycle T+1.
  - With `cfg_count==0`, `m_valid=1` from cycle T+1.
- Throughput: one beat per cycle while `s_rvalid` is held high.
- Latency: last beat accepted at edge L gives `m_valid=1` in cycle L+1, with `m_sum` already final.
- Result acceptance at edge R:
  - IDLE from cycle R+1.
  - A new `cfg_start` is accepted at the earliest at edge R+1.
- `m_ready` may be high before `m_valid`. Acceptance then occurs on the first DONE cycle.

## Configuration
- `RDATA_REDUCER_SATURATE_EN`:
  - Defined: if `acc + lane_sum` exceeds `2^SUM_BITS-1`, the accumulator clamps to all-ones and stays there for the rest of the run.
  - Undefined: the accumulator wraps modulo `2^SUM_BITS`.
  - No other behaviour or timing differs.

## Test plan
- Basic sum: `cfg_count=4`, four back-to-back beats `0x0001_0002_0003_0004` → `m_valid` one cycle after the 4th beat, `m_sum=40`, `m_beats=4`.
- Zero count: `cfg_start` with `cfg_count=0` and `s_rvalid=1` → `s_rready` stays 0, `m_valid` next cycle, `m_sum=0`, `m_beats=0`.
- Bubbles and backpressure: `cfg_count=3`, `s_rvalid` toggling 1,0,0,1,0,1 with data 1, 2, 3 in lane 0, then `m_ready=0` for 5 cycles → `m_sum=6` held stable for 5 cycles. Acceptance occurs on the cycle `m_ready` rises. IDLE the next cycle. `cfg_start` during ACCUM changes nothing.
- Overflow (`SUM_BITS=18`): two beats of `0xFFFF_FFFF_FFFF_FFFF`.
  - Without the macro → `m_sum=0x3FFF8`.
  - With `RDATA_REDUCER_SATURATE_EN` → `m_sum=0x3FFFF`.
- Reset mid-run: `cfg_count=8`, assert `resetn=0` asynchronously after 3 beats → all outputs are 0 immediately. A fresh `cfg_count=1` run with beat `0x0000_0000_0000_0005` then gives `m_sum=5`.
